// File: rtl/neonfox_int_pkg.sv
// Shared definitions for the NeonFox interrupt controller:
// register word offsets, FSM state encoding and CLAIM word layout.
package neonfox_int_pkg;

  // Word offsets from BASE_ADDR
  localparam logic [2:0] REG_PENDING = 3'd0;
  localparam logic [2:0] REG_ENABLE  = 3'd1;
  localparam logic [2:0] REG_CLAIM   = 3'd2;
  localparam logic [2:0] REG_EOI     = 3'd3;
  localparam logic [2:0] REG_EDGE    = 3'd4;
  localparam logic [2:0] REG_SWTRIG  = 3'd5;
  localparam int unsigned NUM_REGS   = 6;

  // Bit position of the valid flag in the CLAIM word
  localparam int unsigned CLAIM_VALID_BIT = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } int_state_t;

endpackage

// File: rtl/neonfox_int_prio_enc.sv
// 16->4 priority encoder: the lowest set index wins; valid flags any set bit.
module neonfox_int_prio_enc (
  input  logic [15:0] req,
  output logic [3:0]  id,
  output logic        valid
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    // NOTE: every output gets a default before any conditional write, so no latch is inferred.
    id    = '0;
    valid = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (req[i]) begin
        id    = 4'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/neonfox_int_ctrl.sv
// NeonFox interrupt controller: latches 16 sources as pending, masks them,
// and presents one request level (int_rq/int_addr) to the core until it is
// claimed over the IO bus and later retired with EOI.
// Build option: define NEONFOX_INT_SYNC_EN to insert a 2-flop synchronizer
// on irq_in (adds two cycles of latency).
module neonfox_int_ctrl
  import neonfox_int_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'hFFE0,
  parameter logic [15:0] RESET_ENABLE = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] irq_in,
  input  logic [15:0] IO_address,
  input  logic        IO_wren,
  input  logic        IO_ren,
  input  logic        H_en,
  input  logic        L_en,
  input  logic [15:0] IO_wdata,
  output logic [15:0] IO_rdata,
  output logic        int_rq,
  output logic [3:0]  int_addr
);

  logic [15:0] irq_s;        // irq_in as seen by the edge detector
  logic [15:0] irq_prev;     // irq_s one cycle ago; also the sampled level
  logic [15:0] pend_reg;     // edge-pending bits plus sticky software triggers
  logic [15:0] enable_reg;
  logic [15:0] edge_reg;
  logic [15:0] pending;
  logic [15:0] cand;
  logic [15:0] wmask;
  logic [15:0] set_bits;
  logic [15:0] clr_bits;
  logic [15:0] offset;
  logic        hit;
  logic        wr_pending, wr_enable, wr_eoi, wr_edge, wr_swtrig, rd_claim;
  logic        claim_take;
  logic [3:0]  win_id;
  logic        win_valid;
  logic [3:0]  addr_q;
  int_state_t  state, state_next;

`ifdef NEONFOX_INT_SYNC_EN
  logic [15:0] sync1, sync2;

  // Two-flop synchronizer for asynchronous sources
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
    end
  end

  assign irq_s = sync2;
`else
  assign irq_s = irq_in;
`endif

  // Address decode and byte-lane mask
  assign offset     = IO_address - BASE_ADDR;
  assign hit        = (offset < 16'(NUM_REGS));
  assign wmask      = {{8{H_en}}, {8{L_en}}};
  assign wr_pending = IO_wren && hit && (offset[2:0] == REG_PENDING);
  assign wr_enable  = IO_wren && hit && (offset[2:0] == REG_ENABLE);
  assign wr_eoi     = IO_wren && hit && (offset[2:0] == REG_EOI);
  assign wr_edge    = IO_wren && hit && (offset[2:0] == REG_EDGE);
  assign wr_swtrig  = IO_wren && hit && (offset[2:0] == REG_SWTRIG);
  assign rd_claim   = IO_ren  && hit && (offset[2:0] == REG_CLAIM);

  // Level sources show the sampled input; sticky bits cover edges and SWTRIG
  assign pending = pend_reg | (irq_prev & ~edge_reg);
  assign cand    = pending & enable_reg;

  // Only edge-mode bits are cleared by a claim; set wins over any clear
  assign set_bits = (irq_s & ~irq_prev & edge_reg)
                  | (wr_swtrig ? (IO_wdata & wmask) : 16'h0000);
  assign clr_bits = (wr_pending ? (IO_wdata & wmask) : 16'h0000)
                  | (claim_take ? (edge_reg & (16'h0001 << addr_q)) : 16'h0000);

  neonfox_int_prio_enc u_prio_enc (
    .req   (cand),
    .id    (win_id),
    .valid (win_valid)
  );

  // Register file, input history and pending latches
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      irq_prev   <= '0;
      pend_reg   <= '0;
      enable_reg <= RESET_ENABLE;
      edge_reg   <= 16'hFFFF;
    end else begin
      irq_prev <= irq_s;
      pend_reg <= (pend_reg & ~clr_bits) | set_bits;
      if (wr_enable) enable_reg <= (enable_reg & ~wmask) | (IO_wdata & wmask);
      if (wr_edge)   edge_reg   <= (edge_reg & ~wmask) | (IO_wdata & wmask);
    end
  end

  // FSM state and latched vector
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      addr_q <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && win_valid) addr_q <= win_id;
    end
  end

  // Next-state logic; a claim takes priority over a lost source
  always_comb begin
    state_next = state;
    claim_take = 1'b0;
    case (state)
      IDLE:    if (win_valid) state_next = ASSERT;
      ASSERT: begin
        if (rd_claim) begin
          state_next = SERVICE;
          claim_take = 1'b1;
        end else if (!cand[addr_q]) begin
          state_next = IDLE;
        end
      end
      SERVICE: if (wr_eoi) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request is high exactly while in ASSERT, straight from the state flops
  assign int_rq   = (state == ASSERT);
  assign int_addr = addr_q;

  // Combinational read mux; unselected or write-only registers read zero
  always_comb begin
    IO_rdata = 16'h0000;
    if (IO_ren && hit) begin
      case (offset[2:0])
        REG_PENDING: IO_rdata = pending;
        REG_ENABLE:  IO_rdata = enable_reg;
        REG_EDGE:    IO_rdata = edge_reg;
        REG_CLAIM: begin
          if (state == ASSERT) begin
            IO_rdata = {12'h000, addr_q};
            IO_rdata[CLAIM_VALID_BIT] = 1'b1;
          end
        end
        default:     IO_rdata = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_neonfox_int_ctrl.sv
// Scoreboard bench for neonfox_int_ctrl: the stimulus thread queues the
// expected IO reads and int_rq edges (value and cycle); a monitor on the
// falling clock edge pops and compares each observed event.
module tb_neonfox_int_ctrl;
  import neonfox_int_pkg::*;

  localparam logic [15:0] BASE = 16'hFFE0;
`ifdef NEONFOX_INT_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] irq_in = '0;
  logic [15:0] IO_address = '0;
  logic        IO_wren = 1'b0;
  logic        IO_ren = 1'b0;
  logic        H_en = 1'b0;
  logic        L_en = 1'b0;
  logic [15:0] IO_wdata = '0;
  logic [15:0] IO_rdata;
  logic        int_rq;
  logic [3:0]  int_addr;

  neonfox_int_ctrl #(.BASE_ADDR(BASE), .RESET_ENABLE(16'h0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .IO_address (IO_address),
    .IO_wren    (IO_wren),
    .IO_ren     (IO_ren),
    .H_en       (H_en),
    .L_en       (L_en),
    .IO_wdata   (IO_wdata),
    .IO_rdata   (IO_rdata),
    .int_rq     (int_rq),
    .int_addr   (int_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum logic [1:0] {EV_READ, EV_RISE, EV_FALL} ev_t;
  typedef struct {
    ev_t         kind;
    logic [15:0] value;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  logic rq_d = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input ev_t k, input logic [15:0] v, input int at);
    exp_t e;
    e.kind  = k;
    e.value = v;
    e.at    = at;
    sb.push_back(e);
  endtask

  task automatic observe(input ev_t k, input logic [15:0] v);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_%s: got %0h at cycle %0d, nothing expected", k.name(), v, cyc);
    end else begin
      e = sb.pop_front();
      check($sformatf("%s_kind", e.kind.name()), 32'(k), 32'(e.kind));
      check($sformatf("%s_value", e.kind.name()), 32'(v), 32'(e.value));
      check($sformatf("%s_cycle", e.kind.name()), 32'(cyc), 32'(e.at));
    end
  endtask

  // Monitor: reads first, then request edges, all sampled mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (IO_ren) observe(EV_READ, IO_rdata);
      if (int_rq && !rq_d) observe(EV_RISE, {12'h000, int_addr});
      if (!int_rq && rq_d) observe(EV_FALL, 16'h0000);
      rq_d = int_rq;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [2:0] off, input logic [15:0] d,
                          input logic h = 1'b1, input logic l = 1'b1);
    IO_address = BASE + 16'(off);
    IO_wdata   = d;
    H_en       = h;
    L_en       = l;
    IO_wren    = 1'b1;
    tick();
    IO_wren = 1'b0;
    H_en    = 1'b0;
    L_en    = 1'b0;
  endtask

  task automatic io_read(input logic [2:0] off, input logic [15:0] exp);
    push(EV_READ, exp, cyc);
    IO_address = BASE + 16'(off);
    IO_ren     = 1'b1;
    tick();
    IO_ren = 1'b0;
  endtask

  // Claim the active request: CLAIM word now, int_rq falls on the next edge
  task automatic claim(input logic [3:0] id);
    push(EV_READ, {12'h800, id}, cyc);
    push(EV_FALL, 16'h0000, cyc + 1);
    IO_address = BASE + 16'(REG_CLAIM);
    IO_ren     = 1'b1;
    tick();
    IO_ren = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    reset = 1'b0;
    check("rst_int_rq", 32'(int_rq), 32'd0);
    check("rst_int_addr", 32'(int_addr), 32'd0);
    io_read(REG_PENDING, 16'h0000);
    io_read(REG_ENABLE, 16'h0000);
    io_read(REG_EDGE, 16'hFFFF);
    io_read(REG_CLAIM, 16'h0000);

    // 1: single edge source, claim clears its pending bit
    io_write(REG_ENABLE, 16'h0008);
    irq_in = 16'h0008;
    push(EV_RISE, 16'd3, cyc + LAT);
    tick();
    irq_in = '0;
    drain(20);
    claim(4'd3);
    drain(5);
    io_read(REG_PENDING, 16'h0000);

    // 2: new source held off during SERVICE, delivered after EOI
    io_write(REG_ENABLE, 16'h000A);
    irq_in = 16'h0002;
    tick();
    irq_in = '0;
    idle(4);
    io_read(REG_PENDING, 16'h0002);
    push(EV_RISE, 16'd1, cyc + 2);
    io_write(REG_EOI, 16'h1234);
    drain(10);
    claim(4'd1);
    drain(5);
    io_write(REG_EOI, 16'h0000);

    // 3: simultaneous sources, lowest index first, then the other
    io_write(REG_ENABLE, 16'hFFFF);
    irq_in = 16'h0024;
    push(EV_RISE, 16'd2, cyc + LAT);
    tick();
    irq_in = '0;
    drain(20);
    claim(4'd2);
    drain(5);
    push(EV_RISE, 16'd5, cyc + 2);
    io_write(REG_EOI, 16'h0000);
    drain(10);
    claim(4'd5);
    drain(5);
    io_write(REG_EOI, 16'h0000);

    // 4: disabling the latched source withdraws the request
    irq_in = 16'h0010;
    push(EV_RISE, 16'd4, cyc + LAT);
    tick();
    irq_in = '0;
    drain(20);
    push(EV_FALL, 16'h0000, cyc + 2);
    io_write(REG_ENABLE, 16'h0000);
    drain(10);
    io_read(REG_CLAIM, 16'h0000);
    io_write(REG_PENDING, 16'h0010);
    io_read(REG_PENDING, 16'h0000);

    // 5: level source re-asserts after EOI; W1C cannot clear a high input
    io_write(REG_EDGE, 16'hFF7F);
    io_write(REG_ENABLE, 16'h0080);
    irq_in = 16'h0080;
    push(EV_RISE, 16'd7, cyc + LAT);
    drain(20);
    claim(4'd7);
    drain(5);
    io_write(REG_PENDING, 16'h0080);
    io_read(REG_PENDING, 16'h0080);
    push(EV_RISE, 16'd7, cyc + 2);
    io_write(REG_EOI, 16'h0000);
    drain(10);
    push(EV_FALL, 16'h0000, cyc + LAT);
    irq_in = '0;
    drain(20);
    io_write(REG_EDGE, 16'hFFFF);
    io_read(REG_PENDING, 16'h0000);

    // 6: byte enables, software triggers, unmapped read
    io_write(REG_ENABLE, 16'hFFFF, 1'b0, 1'b1);
    io_read(REG_ENABLE, 16'h00FF);
    io_write(REG_SWTRIG, 16'h0100);
    io_write(REG_SWTRIG, 16'h0200, 1'b0, 1'b1);
    idle(3);
    io_read(REG_PENDING, 16'h0100);
    io_read(3'd6, 16'h0000);
    push(EV_RISE, 16'd0, cyc + 2);
    io_write(REG_SWTRIG, 16'h0001);
    drain(10);
    claim(4'd0);
    drain(5);
    io_write(REG_EOI, 16'h0000);
    io_read(REG_PENDING, 16'h0100);

    idle(5);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
